// File: rtl/wca_expport_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wca_expport_arbiter
// Purpose  : Round-robin arbiter sharing the 3-bit expansion port among NREQ
//            requesters. The winner's value is latched onto epout and owned
//            for HOLD_CYCLES clocks. An optional GAP_CYCLES idle guard follows
//            before the next grant is issued.
// Ports    : clk     - system clock
//            reset   - synchronous, active-high reset
//            enable  - gates new grants (a sequence in progress still completes)
//            req     - per-requester request level, held until ack
//            data    - requester i value in data[3*i+2:3*i]
//            ack     - one-cycle grant pulse to the winning requester
//            epout   - expansion port output value
//            busy    - high while in HOLD or GAP
//            owner   - index of the last granted requester
// Options  : WCA_EXPPORT_PRIO0_EN - when defined, requester 0 has fixed top
//            priority and does not move the round-robin pointer.
// Revision : 1.0 - initial release
// ============================================================================
module wca_expport_arbiter #(
    parameter int NREQ        = 4,
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [NREQ-1:0]   req,
    input  logic [3*NREQ-1:0] data,
    output logic [NREQ-1:0]   ack,
    output logic [2:0]        epout,
    output logic              busy,
    output logic [2:0]        owner
);

    // The counter only ever holds a reload value (HOLD-1 or GAP-1).
    localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] C_HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_GAP_LOAD  = CNT_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
    localparam logic [2:0]       C_PTR_RST   = 3'(NREQ - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [2:0]        ptr_q,   ptr_d;
    logic [2:0]        epout_q, epout_d;
    logic [NREQ-1:0]   ack_q,   ack_d;
    logic              busy_q,  busy_d;
    logic [2:0]        owner_q, owner_d;

    // ------------------------------------------------------------------------
    // Winner selection
    // ------------------------------------------------------------------------
    logic       w_rr_found;
    logic [2:0] w_rr_win;
    logic       w_found;
    logic [2:0] w_win;
    logic       w_move_ptr;
    logic [2:0] w_win_data;

    // Round-robin search: distance k=1 is the requester just after the
    // pointer; the first asserted request at the smallest distance wins.
    // The double loop keeps every vector index a loop constant.
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_win   = 3'd0;
        for (int k = 1; k <= NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!w_rr_found && req[i] && (((int'(ptr_q) + k) % NREQ) == i)) begin
                    w_rr_found = 1'b1;
                    w_rr_win   = 3'(i);
                end
            end
        end
    end

`ifdef WCA_EXPPORT_PRIO0_EN
    // Requester 0 overrides the rotation and leaves the pointer where it is,
    // so requesters 1..NREQ-1 keep their own fair ordering.
    always_comb begin
        w_found    = 1'b0;
        w_win      = 3'd0;
        w_move_ptr = 1'b0;
        if (req[0]) begin
            w_found    = 1'b1;
            w_win      = 3'd0;
            w_move_ptr = 1'b0;
        end else begin
            w_found    = w_rr_found;
            w_win      = w_rr_win;
            w_move_ptr = w_rr_found;
        end
    end
`else
    always_comb begin
        w_found    = w_rr_found;
        w_win      = w_rr_win;
        w_move_ptr = w_rr_found;
    end
`endif

    always_comb begin
        w_win_data = 3'd0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_win == 3'(i)) begin
                w_win_data = data[3*i +: 3];
            end
        end
    end

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ptr_q   <= C_PTR_RST;
            epout_q <= 3'd0;
            ack_q   <= '0;
            busy_q  <= 1'b0;
            owner_q <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            epout_q <= epout_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            owner_q <= owner_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and registered-output logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        epout_d = epout_q;     // port value persists until the next grant
        ack_d   = '0;          // ack is a single-cycle pulse
        busy_d  = busy_q;
        owner_d = owner_q;

        case (state_q)
            S_IDLE: begin
                if (enable && w_found) begin
                    epout_d = w_win_data;
                    for (int i = 0; i < NREQ; i++) begin
                        ack_d[i] = (w_win == 3'(i));
                    end
                    owner_d = w_win;
                    if (w_move_ptr) begin
                        ptr_d = w_win;
                    end
                    cnt_d   = C_HOLD_LOAD;
                    state_d = S_HOLD;
                    busy_d  = 1'b1;
                end
            end

            S_HOLD: begin
                if (cnt_q == '0) begin
                    if (GAP_CYCLES > 0) begin
                        cnt_d   = C_GAP_LOAD;
                        state_d = S_GAP;
                    end else begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            S_GAP: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign ack   = ack_q;
    assign epout = epout_q;
    assign busy  = busy_q;
    assign owner = owner_q;

endmodule
`default_nettype wire

// File: doc/wca_expport_arbiter.md
Name: wca_expport_arbiter

Overview:
Shares the 3-bit expansion port output between up to NREQ requesters (GPIO flag sources, trigger generators, debug taps). Grants one requester at a time in round-robin order and latches its 3-bit value onto the port. Holds each grant for a minimum dwell time, then inserts a guard gap before the next grant. Sits between the requesters and the expansion port pins, replacing direct single-source latching of the port.

Parameters:
NREQ, 4, number of requesters (2..8).
HOLD_CYCLES, 4, minimum clocks a granted value is owned on epout (>=1).
GAP_CYCLES, 1, idle clocks after a hold before the next grant (0 = none).

Ports:
clk  input  1  system clock.
reset  input  1  reset, synchronous, active-high.
enable  input  1  when low, no new grants are issued; a grant in progress completes.
req  input  NREQ  per-requester request level; held high until ack.
data  input  3*NREQ  requester i value in data[3*i+2:3*i].
ack  output  NREQ  one-cycle pulse to the granted requester when its value is latched.
epout  output  3  expansion port output value.
busy  output  1  high in HOLD or GAP.
owner  output  3  index of last granted requester.

Behaviour:
- Reset values: epout=0, ack=0, busy=0, owner=0. Internal round-robin pointer = NREQ-1, so the first search starts at requester 0. State = IDLE, counter = 0.
- States are IDLE, HOLD and GAP. All outputs are registered.
- IDLE: at a clock edge where enable=1 and req!=0, the arbiter picks the winner.
  - Winner = first asserted req searching upward from pointer+1, wrapping modulo NREQ.
  - Same edge: epout<=data[winner], ack[winner]<=1 for one cycle, owner<=winner, pointer<=winner, counter<=HOLD_CYCLES-1, state<=HOLD, busy<=1.
  - Latency from req sampled to epout/ack = 1 clock.
- HOLD: counter decrements each clock and epout is frozen.
  - At counter==0: go to GAP with counter<=GAP_CYCLES-1 if GAP_CYCLES>0; otherwise go to IDLE with busy<=0.
  - Total ownership = HOLD_CYCLES clocks.
- GAP: epout keeps its last value; no grant is issued. At counter==0, go to IDLE with busy<=0.
- With GAP_CYCLES=0, a pending request is granted on the first IDLE edge: the next grant comes HOLD_CYCLES+1 clocks after the previous one.
- epout retains the last granted value indefinitely while idle; it never returns to 0 except on reset.
- req deasserted before grant: no grant, no ack. A requester deasserts req on the cycle ack is seen. If req is still high after ack, it is treated as a new request and re-arbitrated fairly.
- data is sampled only at the grant edge; changes during HOLD are ignored.
- enable low in IDLE: pending requests wait and no ack is issued. enable low in HOLD/GAP: the sequence completes normally.
- Reset mid-HOLD/GAP: next edge forces all outputs to their reset values, state=IDLE and pointer=NREQ-1.
- Only one ack bit is ever high, and only in the grant cycle.

Optional Feature:
Macro WCA_EXPPORT_PRIO0_EN.
- Defined: requester 0 has fixed top priority and wins whenever req[0]=1 at a grant edge, regardless of pointer. Granting requester 0 does not move the pointer. Requesters 1..NREQ-1 round-robin among themselves.
- Undefined: pure round-robin across all NREQ requesters as described above.

Test Plan:
Use NREQ=4, HOLD_CYCLES=4, GAP_CYCLES=2 unless stated.
- Reset then req=4'b0001, data0=3'b101 -> next edge epout=5, ack=0001 for 1 clk, owner=0, busy high 6 clks.
- req=4'b1111 held continuously, datai=i+1 -> grants in order 0,1,2,3,0, spaced 7 clks apart; epout sequence 1,2,3,4,1.
- GAP_CYCLES=0, req=4'b0110 held -> grants 1,2 exactly 5 clks apart; no ack overlap.
- enable=0 with req=4'b1000 for 10 clks -> no ack, epout unchanged. Then enable=1 -> ack[3] next edge, epout=data3.
- Reset asserted during HOLD with epout=3'b111 -> next edge epout=0, busy=0, owner=0. A later req=4'b0010 is granted to requester 1.
- WCA_EXPPORT_PRIO0_EN defined, req=4'b0011 held continuously -> requester 0 wins every grant. Drop req[0] -> requester 1 granted at the next IDLE edge.
